// File: rtl/hello_scroll_led7.sv
// hello_scroll_led7: self-running HELLO scroller for an active-low 7-segment bank.
// A prescaler advances a rotation position. HEX is registered from that position,
// with optional pause, single-step, direction control and direct position load.
module hello_scroll_led7 #(
  parameter int unsigned N_DIG    = 8,
  parameter int unsigned MSG_LEN  = 8,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         dir,
  input  logic                         step,
  input  logic                         load,
  input  logic [$clog2(MSG_LEN)-1:0]   pos_in,
  output logic [$clog2(MSG_LEN)-1:0]   pos,
  output logic                         tick,
  output logic [8*N_DIG-1:0]           HEX
);

  localparam int unsigned PW = $clog2(MSG_LEN);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);

  logic [CW-1:0]      count;
  logic               term;
  logic               advance;
  logic [PW-1:0]      pos_next;
  logic [8*N_DIG-1:0] hex_next;

  // Message ROM: H, E, L, L, O, then blanks.
  function automatic logic [7:0] glyph(input int unsigned k);
    case (k)
      0:       glyph = 8'h89;
      1:       glyph = 8'h86;
      2, 3:    glyph = 8'hC7;
      4:       glyph = 8'hC0;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Advance decode and the wrapped next position in the selected direction.
  always_comb begin
    term    = (count == CNT_LAST);
    advance = (run & term) | (~run & step);
    if (dir == 1'b0) pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
    else             pos_next = (pos == '0) ? POS_LAST : pos - 1'b1;
  end

  // Prescaler, tick pulse and position register. A load takes priority over an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
      pos   <= '0;
    end else if (load) begin
      count <= '0;
      tick  <= 1'b0;
      pos   <= (32'(pos_in) >= MSG_LEN) ? '0 : pos_in;
    end else begin
      if (run) count <= term ? '0 : count + 1'b1;
      tick <= run & term;
      if (advance) pos <= pos_next;
    end
  end

  // Digit d shows msg[(pos - d + 4) mod MSG_LEN]. The added MSG_LEN keeps the index non-negative.
  always_comb begin
    hex_next = '1;
    for (int unsigned d = 0; d < N_DIG; d++) begin
      hex_next[8*d +: 8] = glyph((32'(pos) + MSG_LEN + 4 - d) % MSG_LEN);
    end
  end

  // HEX lags pos by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) HEX <= '1;
    else        HEX <= hex_next;
  end

endmodule

// File: tb/tb_hello_scroll_led7.sv
// tb_hello_scroll_led7: directed checks of hello_scroll_led7 using hand-computed expectations.
module tb_hello_scroll_led7;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance: TICK_DIV=4, N_DIG=8, MSG_LEN=8.
  logic       run, dir, step, load;
  logic [2:0] pos_in, pos;
  logic       tick;
  logic [63:0] hex;

  // MSG_LEN=6 instance, used for the out-of-range load and the 6-slot wrap.
  logic       load6;
  logic [2:0] pos_in6, pos6;
  logic       tick6;
  logic [47:0] hex6;

  // TICK_DIV=1 instance.
  logic       run1;
  logic [2:0] pos1;
  logic       tick1;
  logic [63:0] hex1;

  logic       zero = 1'b0;
  logic [2:0] zero3 = 3'd0;

  int checks = 0;
  int failures = 0;

  hello_scroll_led7 #(.N_DIG(8), .MSG_LEN(8), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .step(step), .load(load),
    .pos_in(pos_in), .pos(pos), .tick(tick), .HEX(hex)
  );

  hello_scroll_led7 #(.N_DIG(6), .MSG_LEN(6), .TICK_DIV(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .run(zero), .dir(zero), .step(zero), .load(load6),
    .pos_in(pos_in6), .pos(pos6), .tick(tick6), .HEX(hex6)
  );

  hello_scroll_led7 #(.N_DIG(8), .MSG_LEN(8), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .dir(zero), .step(zero), .load(zero),
    .pos_in(zero3), .pos(pos1), .tick(tick1), .HEX(hex1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0; load = 1'b0; pos_in = '0;
    load6 = 1'b0; pos_in6 = '0; run1 = 1'b1;
    cyc(2);
    check("rst_pos", 64'(pos), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_hex", hex, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_hex1", hex1, 64'hFFFF_FFFF_FFFF_FFFF);

    rst_n = 1'b1;
    cyc(1);
    check("rel_pos", 64'(pos), 64'd0);
    check("rel_hex", hex, 64'hFFFF_FF89_86C7_C7C0);
    check("div1_pos_a", 64'(pos1), 64'd1);
    check("div1_tick_a", 64'(tick1), 64'd1);
    cyc(1);
    check("div1_pos_b", 64'(pos1), 64'd2);
    check("div1_tick_b", 64'(tick1), 64'd1);
    check("paused_pos", 64'(pos), 64'd0);
    run1 = 1'b0;

    // MSG_LEN=6 instance: load 3 and check its display, then an out-of-range load.
    load6 = 1'b1; pos_in6 = 3'd3;
    cyc(1);
    load6 = 1'b0;
    check("m6_load3", 64'(pos6), 64'd3);
    cyc(1);
    check("m6_hex3", 64'(hex6), 64'hC7C7_C0FF_8986);
    load6 = 1'b1; pos_in6 = 3'd6;
    cyc(1);
    load6 = 1'b0;
    check("m6_load6", 64'(pos6), 64'd0);

    // Free-running forward scroll through a full wrap.
    run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k == 5) check("fwd_hex_p4", hex, 64'h86C7_C7C0_FFFF_FF89);
      cyc(2);
      check("fwd_notick", 64'(tick), 64'd0);
      cyc(1);
      check("fwd_tick", 64'(tick), 64'd1);
      check("fwd_pos", 64'(pos), 64'(k % 8));
    end

    // Reverse from 0 wraps to 7.
    dir = 1'b1;
    cyc(4);
    check("rev_pos", 64'(pos), 64'd7);
    check("rev_tick", 64'(tick), 64'd1);
    cyc(1);
    check("rev_hex", hex, 64'hC0FF_FFFF_8986_C7C7);

    // Paused single-stepping from 6, forward.
    run = 1'b0;
    load = 1'b1; pos_in = 3'd6;
    cyc(1);
    load = 1'b0; dir = 1'b0;
    check("load6", 64'(pos), 64'd6);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      check("step_pos", 64'(pos), 64'((7 + k) % 8));
      check("step_notick", 64'(tick), 64'd0);
    end

    // A step while running is ignored.
    run = 1'b1; step = 1'b1;
    cyc(1);
    step = 1'b0;
    check("step_run_ign", 64'(pos), 64'd1);

    // A load that coincides with the prescaler terminal count wins and restarts the count.
    cyc(2);
    load = 1'b1; pos_in = 3'd5;
    cyc(1);
    load = 1'b0;
    check("load_term_pos", 64'(pos), 64'd5);
    check("load_term_tick", 64'(tick), 64'd0);
    cyc(3);
    check("post_load_notick", 64'(tick), 64'd0);
    check("post_load_hold", 64'(pos), 64'd5);
    cyc(1);
    check("post_load_tick", 64'(tick), 64'd1);
    check("post_load_pos", 64'(pos), 64'd6);

    // Load 7, then load and step together.
    run = 1'b0;
    load = 1'b1; pos_in = 3'd7;
    cyc(1);
    check("load7", 64'(pos), 64'd7);
    pos_in = 3'd2; step = 1'b1;
    cyc(1);
    load = 1'b0; step = 1'b0;
    check("load_step", 64'(pos), 64'd2);

    // Asynchronous reset asserted in the middle of a count.
    load = 1'b1; pos_in = 3'd3;
    cyc(1);
    load = 1'b0; run = 1'b1;
    cyc(2);
    check("pre_rst_pos", 64'(pos), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_pos", 64'(pos), 64'd0);
    check("async_tick", 64'(tick), 64'd0);
    check("async_hex", hex, 64'hFFFF_FFFF_FFFF_FFFF);
    rst_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
